midi_voice_alloc: RTL

- Polyphonic voice allocator directly downstream of the MIDI message parser.
- Consumes one parsed message per valid pulse and filters it by channel. Note On / Note Off / All Notes Off messages update a bank of NUM_VOICES voice registers (note, velocity, gate).
- Emits one update strobe per voice change for the oscillator/envelope bank.
- Allocation priority: retrigger a matching note, else the lowest-index free voice, else steal the least-recently-triggered voice.

---
 rtl/midi_voice_alloc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator fed by the MIDI parser.
// Retrigger a held note, else lowest free voice, else steal the oldest.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 8,
  parameter int CHANNEL    = 0,
  parameter bit OMNI       = 1'b0,
  localparam int VW        = $clog2(NUM_VOICES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    msg_valid,
  input  logic [6:0]              status,
  input  logic [6:0]              data1,
  input  logic [6:0]              data2,
  output logic                    busy,
  output logic                    overrun,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [NUM_VOICES*7-1:0] voice_note,
  output logic [NUM_VOICES*7-1:0] voice_vel,
  output logic                    upd_valid,
  output logic [VW-1:0]           upd_voice,
  output logic [6:0]              upd_note,
  output logic [6:0]              upd_vel,
  output logic                    upd_gate,
  output logic                    all_off
);

  typedef enum logic [1:0] {
    IDLE, SCAN, COMMIT, CLEAR
  } state_t;

  state_t state, state_nx;

  logic [NUM_VOICES-1:0] gate_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [6:0]            vel_q  [NUM_VOICES];
  logic [VW-1:0]         age_q  [NUM_VOICES];

  logic [VW-1:0] idx;
  logic          lon;
  logic [6:0]    lnote;
  logic [6:0]    lvel;
  logic          match_found;
  logic          free_found;
  logic [VW-1:0] match_idx;
  logic [VW-1:0] free_idx;
  logic [VW-1:0] old_idx;
  logic [VW-1:0] target;

  logic ch_ok, is_on, is_off, is_all, accept;

  always_comb begin
    ch_ok  = OMNI || (status[3:0] == 4'(CHANNEL));
    is_on  = (status[6:4] == 3'b001) && (data2 != 7'd0);
    is_off = ((status[6:4] == 3'b001) && (data2 == 7'd0))
          || (status[6:4] == 3'b000);
    is_all = (status[6:4] == 3'b011) && (data1 == 7'd123);
    accept = msg_valid && (state == IDLE) && ch_ok;
  end

  always_comb begin
    target = old_idx;
    if (match_found)     target = match_idx;
    else if (free_found) target = free_idx;
  end

  assign busy       = (state != IDLE);
  assign voice_gate = gate_q;

  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_q[i];
      voice_vel[7*i +: 7]  = vel_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept && (is_on || is_off)) state_nx = SCAN;
        else if (accept && is_all)       state_nx = CLEAR;
      end
      SCAN:
        if (idx == VW'(NUM_VOICES - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gate_q      <= '0;
      idx         <= '0;
      lon         <= 1'b0;
      lnote       <= '0;
      lvel        <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      overrun     <= 1'b0;
      upd_valid   <= 1'b0;
      upd_voice   <= '0;
      upd_note    <= '0;
      upd_vel     <= '0;
      upd_gate    <= 1'b0;
      all_off     <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
        age_q[i]  <= VW'(i);
      end
    end else begin
      upd_valid <= 1'b0;
      all_off   <= 1'b0;
      overrun   <= msg_valid && busy;
      unique case (state)
        IDLE: begin
          if (accept && (is_on || is_off)) begin
            lon         <= is_on;
            lnote       <= data1;
            lvel        <= data2;
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
          end
        end
        SCAN: begin
          idx <= idx + VW'(1);
          if (gate_q[idx] && note_q[idx] == lnote && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!gate_q[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          if (age_q[idx] == VW'(NUM_VOICES - 1)) old_idx <= idx;
        end
        COMMIT: begin
          if (lon) begin
            gate_q[target] <= 1'b1;
            note_q[target] <= lnote;
            vel_q[target]  <= lvel;
            // Age is a rank: voices younger than the target shift back one.
            for (int j = 0; j < NUM_VOICES; j++)
              if (age_q[j] < age_q[target])
                age_q[j] <= age_q[j] + VW'(1);
            age_q[target] <= '0;
            upd_valid <= 1'b1;
            upd_voice <= target;
            upd_note  <= lnote;
            upd_vel   <= lvel;
            upd_gate  <= 1'b1;
          end else if (match_found) begin
            gate_q[match_idx] <= 1'b0;
            upd_valid <= 1'b1;
            upd_voice <= match_idx;
            upd_note  <= note_q[match_idx];
            upd_vel   <= vel_q[match_idx];
            upd_gate  <= 1'b0;
          end
        end
        CLEAR: begin
          gate_q  <= '0;
          all_off <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
